// File: rtl/wback_pkg.sv
// Shared definitions for the writeback stage: FSM state encoding, write-select
// codes and default bus widths.
package wback_pkg;

  localparam int XLEN_DEFAULT       = 32;
  localparam int REG_ADDR_W_DEFAULT = 5;
  localparam int CSR_OP_W           = 8;
  localparam int CSR_ADDR_W         = 32;
  localparam int INSTRET_W          = 64;

  // GPR write-data source select
  localparam logic WSEL_ALU = 1'b0;
  localparam logic WSEL_MEM = 1'b1;

  typedef enum logic [1:0] {
    WB_IDLE   = 2'd0,
    WB_WRITE  = 2'd1,
    WB_COMMIT = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wback_controller.sv
// Writeback control FSM: IDLE accepts one instruction, WRITE is the single
// strobe cycle, COMMIT holds valid_post_o until the consumer takes the retire.
module wback_controller
  import wback_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic valid_pre_i,
  input  logic ready_post_i,
  output logic ready_pre_o,
  output logic valid_post_o,
  output logic we_o,
  output logic write_phase_o
);

  wb_state_e r_state;
  wb_state_e w_next_state;

  // State register; reset sends the FSM straight back to IDLE, dropping any pending work
  // NOTE: sequential state uses <= so every flop samples the pre-edge values of its peers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= WB_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state and handshake outputs decoded from the current state
  // NOTE: every output gets a default first so no path through the case can infer a latch.
  always_comb begin
    w_next_state  = r_state;
    ready_pre_o   = 1'b0;
    valid_post_o  = 1'b0;
    we_o          = 1'b0;
    write_phase_o = 1'b0;
    case (r_state)
      WB_IDLE: begin
        // ready is masked while reset is held so upstream never sees a false accept
        ready_pre_o = !reset;
        we_o        = valid_pre_i && !reset;
        if (we_o) w_next_state = WB_WRITE;
      end
      WB_WRITE: begin
        write_phase_o = 1'b1;
        w_next_state  = WB_COMMIT;
      end
      WB_COMMIT: begin
        valid_post_o = 1'b1;
        if (ready_post_i) w_next_state = WB_IDLE;
      end
      default: w_next_state = WB_IDLE;
    endcase
  end

endmodule

// File: rtl/wback.sv
// Writeback stage top: captures one executed instruction, selects GPR write
// data, pulses the GPR and CSR write strobes once, then retires.
// Optional feature macro: WBACK_INSTRET_EN adds a 64-bit retired-instruction
// counter and the instret_o port.
module wback
  import wback_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  valid_pre_i,
  output logic                  ready_pre_o,
  output logic                  valid_post_o,
  input  logic                  ready_post_i,
  input  logic                  wsel_i,
  input  logic                  wena_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic [XLEN-1:0]       alu_result_i,
  input  logic [XLEN-1:0]       mem_result_i,
  input  logic [CSR_OP_W-1:0]   csr_op_i,
  input  logic                  csr_wena_i,
  input  logic [CSR_ADDR_W-1:0] csr_waddr_i,
  input  logic [XLEN-1:0]       csr_wdata_i,
  output logic                  wena_o,
  output logic [REG_ADDR_W-1:0] waddr_o,
  output logic [XLEN-1:0]       wdata_o,
  output logic [CSR_OP_W-1:0]   csr_op_o,
  output logic                  csr_wena_o,
  output logic [CSR_ADDR_W-1:0] csr_waddr_o,
  output logic [XLEN-1:0]       csr_wdata_o
`ifdef WBACK_INSTRET_EN
  ,
  output logic [INSTRET_W-1:0]  instret_o
`endif
);

  logic w_we;
  logic w_write_phase;

  logic                  r_wsel;
  logic                  r_wena;
  logic [REG_ADDR_W-1:0] r_waddr;
  logic [XLEN-1:0]       r_alu_result;
  logic [XLEN-1:0]       r_mem_result;
  logic [CSR_OP_W-1:0]   r_csr_op;
  logic                  r_csr_wena;
  logic [CSR_ADDR_W-1:0] r_csr_waddr;
  logic [XLEN-1:0]       r_csr_wdata;

  wback_controller u_ctrl (
    .clock        (clock),
    .reset        (reset),
    .valid_pre_i  (valid_pre_i),
    .ready_post_i (ready_post_i),
    .ready_pre_o  (ready_pre_o),
    .valid_post_o (valid_post_o),
    .we_o         (w_we),
    .write_phase_o(w_write_phase)
  );

  // Capture registers: loaded only on accept so outputs stay stable through WRITE and COMMIT
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wsel       <= WSEL_ALU;
      r_wena       <= 1'b0;
      r_waddr      <= '0;
      r_alu_result <= '0;
      r_mem_result <= '0;
      r_csr_op     <= '0;
      r_csr_wena   <= 1'b0;
      r_csr_waddr  <= '0;
      r_csr_wdata  <= '0;
    end else if (w_we) begin
      r_wsel       <= wsel_i;
      r_wena       <= wena_i;
      r_waddr      <= waddr_i;
      r_alu_result <= alu_result_i;
      r_mem_result <= mem_result_i;
      r_csr_op     <= csr_op_i;
      r_csr_wena   <= csr_wena_i;
      r_csr_waddr  <= csr_waddr_i;
      r_csr_wdata  <= csr_wdata_i;
    end
  end

  // Only the strobes are pulsed; x0 is never written
  assign wena_o      = w_write_phase && r_wena && (r_waddr != '0);
  assign csr_wena_o  = w_write_phase && r_csr_wena;
  assign waddr_o     = r_waddr;
  assign wdata_o     = (r_wsel == WSEL_MEM) ? r_mem_result : r_alu_result;
  assign csr_op_o    = r_csr_op;
  assign csr_waddr_o = r_csr_waddr;
  assign csr_wdata_o = r_csr_wdata;

`ifdef WBACK_INSTRET_EN
  logic                 w_retire;
  logic [INSTRET_W-1:0] r_instret;

  assign w_retire = valid_post_o && ready_post_i;

  // Retired-instruction counter, wraps naturally at 2^64
  always_ff @(posedge clock or posedge reset) begin
    if (reset)         r_instret <= '0;
    else if (w_retire) r_instret <= r_instret + 64'd1;
  end

  assign instret_o = r_instret;
`endif

endmodule

// File: tb/tb_wback.sv
// Self-checking bench for wback: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_wback;
  import wback_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid_pre_i, ready_post_i;
  logic        ready_pre_o, valid_post_o;
  logic        wsel_i, wena_i, csr_wena_i;
  logic [4:0]  waddr_i;
  logic [31:0] alu_result_i, mem_result_i, csr_waddr_i, csr_wdata_i;
  logic [7:0]  csr_op_i;
  logic        wena_o, csr_wena_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o, csr_waddr_o, csr_wdata_o;
  logic [7:0]  csr_op_o;
`ifdef WBACK_INSTRET_EN
  logic [63:0] instret_o;
`endif

  always #5 clock = ~clock;

  wback dut (
    .clock       (clock),
    .reset       (reset),
    .valid_pre_i (valid_pre_i),
    .ready_pre_o (ready_pre_o),
    .valid_post_o(valid_post_o),
    .ready_post_i(ready_post_i),
    .wsel_i      (wsel_i),
    .wena_i      (wena_i),
    .waddr_i     (waddr_i),
    .alu_result_i(alu_result_i),
    .mem_result_i(mem_result_i),
    .csr_op_i    (csr_op_i),
    .csr_wena_i  (csr_wena_i),
    .csr_waddr_i (csr_waddr_i),
    .csr_wdata_i (csr_wdata_i),
    .wena_o      (wena_o),
    .waddr_o     (waddr_o),
    .wdata_o     (wdata_o),
    .csr_op_o    (csr_op_o),
    .csr_wena_o  (csr_wena_o),
    .csr_waddr_o (csr_waddr_o),
    .csr_wdata_o (csr_wdata_o)
`ifdef WBACK_INSTRET_EN
    ,
    .instret_o   (instret_o)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;
  longint unsigned exp_instret = 0;

  typedef struct packed {
    logic        wsel;
    logic        wena;
    logic [4:0]  waddr;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [7:0]  csr_op;
    logic        csr_wena;
    logic [31:0] csr_waddr;
    logic [31:0] csr_wdata;
  } txn_t;

  // What the bench saw over one transaction's lifetime
  typedef struct packed {
    logic        ready_before;
    logic        pulse_in_write;
    logic        csr_pulse_in_write;
    logic        valid_in_write;
    logic [31:0] wena_pulses;
    logic [31:0] csr_pulses;
    logic [31:0] valid_cycles;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [7:0]  csr_op;
    logic [31:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        busy_ready;
    logic        hold_moved;
    logic        idle_after;
  } obs_t;

  function automatic txn_t make_txn(logic wsel, logic wena, logic [4:0] waddr, logic [31:0] alu,
                                    logic [31:0] mem, logic [7:0] op, logic cw, logic [31:0] ca,
                                    logic [31:0] cd);
    txn_t t;
    t.wsel = wsel; t.wena = wena; t.waddr = waddr; t.alu = alu; t.mem = mem;
    t.csr_op = op; t.csr_wena = cw; t.csr_waddr = ca; t.csr_wdata = cd;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.wsel      = 1'($urandom_range(0, 1));
    t.wena      = 1'($urandom_range(0, 1));
    t.waddr     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    t.alu       = $urandom;
    t.mem       = $urandom;
    t.csr_op    = 8'($urandom);
    t.csr_wena  = 1'($urandom_range(0, 1));
    t.csr_waddr = $urandom;
    t.csr_wdata = $urandom;
    return t;
  endfunction

  // Offer one instruction, observe WRITE/COMMIT, and retire after `stall` refused edges.
  // With keep_valid, valid_pre_i stays high with scrambled data while busy.
  task automatic do_txn(input txn_t t, input int stall, input bit keep_valid, output obs_t o);
    o = '0;
    @(negedge clock);
    o.ready_before = ready_pre_o;
    wsel_i = t.wsel; wena_i = t.wena; waddr_i = t.waddr;
    alu_result_i = t.alu; mem_result_i = t.mem; csr_op_i = t.csr_op;
    csr_wena_i = t.csr_wena; csr_waddr_i = t.csr_waddr; csr_wdata_i = t.csr_wdata;
    valid_pre_i  = 1'b1;
    ready_post_i = (stall == 0);
    @(negedge clock);
    if (keep_valid) begin
      alu_result_i = ~t.alu; mem_result_i = ~t.mem; waddr_i = ~t.waddr;
      csr_wdata_i = ~t.csr_wdata; wena_i = 1'b1; csr_wena_i = 1'b1;
    end else begin
      valid_pre_i = 1'b0;
    end
    o.pulse_in_write     = wena_o;
    o.csr_pulse_in_write = csr_wena_o;
    o.valid_in_write     = valid_post_o;
    o.waddr = waddr_o; o.wdata = wdata_o; o.csr_op = csr_op_o;
    o.csr_waddr = csr_waddr_o; o.csr_wdata = csr_wdata_o;
    if (wena_o) o.wena_pulses++;
    if (csr_wena_o) o.csr_pulses++;
    if (ready_pre_o) o.busy_ready = 1'b1;
    for (int c = 0; c <= stall; c++) begin
      @(negedge clock);
      if (valid_post_o) o.valid_cycles++;
      if (wena_o) o.wena_pulses++;
      if (csr_wena_o) o.csr_pulses++;
      if (ready_pre_o) o.busy_ready = 1'b1;
      if (wdata_o !== o.wdata || waddr_o !== o.waddr || csr_op_o !== o.csr_op ||
          csr_waddr_o !== o.csr_waddr || csr_wdata_o !== o.csr_wdata) o.hold_moved = 1'b1;
      if (c == stall) ready_post_i = 1'b1;
    end
    @(negedge clock);
    o.idle_after = ready_pre_o && !valid_post_o;
    if (wena_o) o.wena_pulses++;
    if (csr_wena_o) o.csr_pulses++;
    valid_pre_i  = 1'b0;
    ready_post_i = 1'b0;
    exp_instret++;
  endtask

  task automatic test_reset();
    reset = 1'b1; valid_pre_i = 1'b0; ready_post_i = 1'b0;
    wsel_i = 1'b0; wena_i = 1'b0; waddr_i = '0; alu_result_i = '0; mem_result_i = '0;
    csr_op_i = '0; csr_wena_i = 1'b0; csr_waddr_i = '0; csr_wdata_i = '0;
    repeat (2) @(negedge clock);
    n_total++; if (ready_pre_o !== 1'b0) $display("FAIL reset_ready_pre: got %b want 0", ready_pre_o); else n_pass++;
    n_total++; if (valid_post_o !== 1'b0) $display("FAIL reset_valid_post: got %b want 0", valid_post_o); else n_pass++;
    n_total++; if ({wena_o, csr_wena_o} !== 2'b00) $display("FAIL reset_strobes: got %b want 00", {wena_o, csr_wena_o}); else n_pass++;
    n_total++; if ({waddr_o, wdata_o, csr_op_o, csr_waddr_o, csr_wdata_o} !== '0)
      $display("FAIL reset_data: got %h %h %h %h %h want all 0", waddr_o, wdata_o, csr_op_o, csr_waddr_o, csr_wdata_o); else n_pass++;
`ifdef WBACK_INSTRET_EN
    n_total++; if (instret_o !== 64'd0) $display("FAIL reset_instret: got %0d want 0", instret_o); else n_pass++;
`endif
    reset = 1'b0;
    @(negedge clock);
    n_total++; if (ready_pre_o !== 1'b1) $display("FAIL idle_ready_pre: got %b want 1", ready_pre_o); else n_pass++;
    exp_instret = 0;
  endtask

  task automatic test_alu_write();
    obs_t o;
    do_txn(make_txn(WSEL_ALU, 1'b1, 5'd5, 32'h1234, 32'h0, 8'h0, 1'b0, 32'h0, 32'h0), 0, 1'b0, o);
    n_total++; if (o.ready_before !== 1'b1) $display("FAIL alu_ready_before: got %b want 1", o.ready_before); else n_pass++;
    n_total++; if (o.pulse_in_write !== 1'b1) $display("FAIL alu_pulse_at_write: got %b want 1", o.pulse_in_write); else n_pass++;
    n_total++; if (o.wena_pulses !== 32'd1) $display("FAIL alu_pulse_count: got %0d want 1", o.wena_pulses); else n_pass++;
    n_total++; if (o.waddr !== 5'd5) $display("FAIL alu_waddr: got %0d want 5", o.waddr); else n_pass++;
    n_total++; if (o.wdata !== 32'h1234) $display("FAIL alu_wdata: got %h want 00001234", o.wdata); else n_pass++;
    n_total++; if (o.valid_in_write !== 1'b0) $display("FAIL alu_early_valid: got %b want 0", o.valid_in_write); else n_pass++;
    n_total++; if (o.valid_cycles !== 32'd1) $display("FAIL alu_valid_cycles: got %0d want 1", o.valid_cycles); else n_pass++;
    n_total++; if (o.idle_after !== 1'b1) $display("FAIL alu_idle_after: got %b want 1", o.idle_after); else n_pass++;
    n_total++; if (o.csr_pulses !== 32'd0) $display("FAIL alu_no_csr: got %0d want 0", o.csr_pulses); else n_pass++;
  endtask

  task automatic test_load_write();
    obs_t o;
    do_txn(make_txn(WSEL_MEM, 1'b1, 5'd9, 32'h1, 32'hDEADBEEF, 8'h0, 1'b0, 32'h0, 32'h0), 0, 1'b0, o);
    n_total++; if (o.wdata !== 32'hDEADBEEF) $display("FAIL load_wdata: got %h want deadbeef", o.wdata); else n_pass++;
    n_total++; if (o.wena_pulses !== 32'd1) $display("FAIL load_pulse_count: got %0d want 1", o.wena_pulses); else n_pass++;
  endtask

  task automatic test_x0();
    obs_t o;
    do_txn(make_txn(WSEL_ALU, 1'b1, 5'd0, 32'hCAFE, 32'h0, 8'h0, 1'b0, 32'h0, 32'h0), 0, 1'b0, o);
    n_total++; if (o.wena_pulses !== 32'd0) $display("FAIL x0_suppress: got %0d pulses want 0", o.wena_pulses); else n_pass++;
    n_total++; if (o.valid_cycles !== 32'd1) $display("FAIL x0_retire: got %0d want 1", o.valid_cycles); else n_pass++;
  endtask

  task automatic test_backpressure();
    obs_t o;
    do_txn(make_txn(WSEL_ALU, 1'b1, 5'd3, 32'h55AA, 32'h0, 8'h7, 1'b1, 32'h300, 32'h1), 5, 1'b1, o);
    n_total++; if (o.valid_cycles !== 32'd6) $display("FAIL bp_valid_held: got %0d want 6", o.valid_cycles); else n_pass++;
    n_total++; if (o.wena_pulses !== 32'd1) $display("FAIL bp_single_pulse: got %0d want 1", o.wena_pulses); else n_pass++;
    n_total++; if (o.csr_pulses !== 32'd1) $display("FAIL bp_single_csr: got %0d want 1", o.csr_pulses); else n_pass++;
    n_total++; if (o.busy_ready !== 1'b0) $display("FAIL bp_ready_pre_busy: got %b want 0", o.busy_ready); else n_pass++;
    n_total++; if (o.hold_moved !== 1'b0) $display("FAIL bp_data_hold: got %b want 0", o.hold_moved); else n_pass++;
    n_total++; if (o.idle_after !== 1'b1) $display("FAIL bp_release_idle: got %b want 1", o.idle_after); else n_pass++;
  endtask

  task automatic test_csr();
    obs_t o;
    do_txn(make_txn(WSEL_ALU, 1'b0, 5'd1, 32'h0, 32'h0, 8'h21, 1'b1, 32'h341, 32'h80000000), 1, 1'b0, o);
    n_total++; if (o.csr_pulse_in_write !== 1'b1) $display("FAIL csr_pulse_at_write: got %b want 1", o.csr_pulse_in_write); else n_pass++;
    n_total++; if (o.csr_pulses !== 32'd1) $display("FAIL csr_pulse_count: got %0d want 1", o.csr_pulses); else n_pass++;
    n_total++; if (o.csr_waddr !== 32'h341) $display("FAIL csr_waddr: got %h want 00000341", o.csr_waddr); else n_pass++;
    n_total++; if (o.csr_wdata !== 32'h80000000) $display("FAIL csr_wdata: got %h want 80000000", o.csr_wdata); else n_pass++;
    n_total++; if (o.csr_op !== 8'h21) $display("FAIL csr_op: got %h want 21", o.csr_op); else n_pass++;
    n_total++; if (o.wena_pulses !== 32'd0) $display("FAIL csr_no_gpr: got %0d want 0", o.wena_pulses); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic seen;
    @(negedge clock);
    wsel_i = WSEL_ALU; wena_i = 1'b1; waddr_i = 5'd7; alu_result_i = 32'h77;
    csr_wena_i = 1'b1; csr_waddr_i = 32'h342; csr_wdata_i = 32'h9;
    valid_pre_i = 1'b1; ready_post_i = 1'b1;
    @(negedge clock);
    valid_pre_i = 1'b0;
    n_total++; if (wena_o !== 1'b1) $display("FAIL rm_pulse_before_reset: got %b want 1", wena_o); else n_pass++;
    #1 reset = 1'b1;
    #1;
    n_total++; if ({wena_o, csr_wena_o} !== 2'b00) $display("FAIL rm_strobes_drop: got %b want 00", {wena_o, csr_wena_o}); else n_pass++;
    n_total++; if ({ready_pre_o, valid_post_o} !== 2'b00) $display("FAIL rm_handshake: got %b want 00", {ready_pre_o, valid_post_o}); else n_pass++;
    n_total++; if (waddr_o !== 5'd0) $display("FAIL rm_waddr_clear: got %0d want 0", waddr_o); else n_pass++;
    @(negedge clock);
    reset = 1'b0;
    exp_instret = 0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (valid_post_o || wena_o || csr_wena_o) seen = 1'b1;
    end
    n_total++; if (seen !== 1'b0) $display("FAIL rm_no_retire: got %b want 0", seen); else n_pass++;
    n_total++; if (ready_pre_o !== 1'b1) $display("FAIL rm_back_idle: got %b want 1", ready_pre_o); else n_pass++;
    ready_post_i = 1'b0;
  endtask

`ifdef WBACK_INSTRET_EN
  task automatic test_instret();
    obs_t o;
    repeat (3) do_txn(rand_txn(), 0, 1'b0, o);
    n_total++; if (instret_o !== exp_instret) $display("FAIL instret_count: got %0d want %0d", instret_o, exp_instret); else n_pass++;
    @(negedge clock);
    reset = 1'b1;
    #1;
    n_total++; if (instret_o !== 64'd0) $display("FAIL instret_reset: got %0d want 0", instret_o); else n_pass++;
    @(negedge clock);
    reset = 1'b0;
    exp_instret = 0;
  endtask
`endif

  task automatic test_random();
    obs_t o;
    txn_t t;
    int   stall;
    bit   kv;
    for (int i = 0; i < 40; i++) begin
      t     = rand_txn();
      stall = $urandom_range(0, 3);
      kv    = 1'($urandom_range(0, 1));
      do_txn(t, stall, kv, o);
      n_total++; if (o.wena_pulses !== 32'(t.wena && (t.waddr != 0)))
        $display("FAIL rnd%0d_gpr_pulses: got %0d want %0d", i, o.wena_pulses, t.wena && (t.waddr != 0)); else n_pass++;
      n_total++; if (o.csr_pulses !== 32'(t.csr_wena))
        $display("FAIL rnd%0d_csr_pulses: got %0d want %0d", i, o.csr_pulses, t.csr_wena); else n_pass++;
      n_total++; if (o.wdata !== (t.wsel ? t.mem : t.alu))
        $display("FAIL rnd%0d_wdata: got %h want %h", i, o.wdata, t.wsel ? t.mem : t.alu); else n_pass++;
      n_total++; if ({o.waddr, o.csr_op, o.csr_waddr, o.csr_wdata} !== {t.waddr, t.csr_op, t.csr_waddr, t.csr_wdata})
        $display("FAIL rnd%0d_fields: got %h %h %h %h want %h %h %h %h", i, o.waddr, o.csr_op, o.csr_waddr,
                 o.csr_wdata, t.waddr, t.csr_op, t.csr_waddr, t.csr_wdata); else n_pass++;
      n_total++; if (o.valid_cycles !== 32'(stall + 1))
        $display("FAIL rnd%0d_valid_cycles: got %0d want %0d", i, o.valid_cycles, stall + 1); else n_pass++;
      n_total++; if ({o.busy_ready, o.hold_moved, o.idle_after} !== 3'b001)
        $display("FAIL rnd%0d_flow: got busy_ready=%b hold_moved=%b idle=%b want 0 0 1", i, o.busy_ready,
                 o.hold_moved, o.idle_after); else n_pass++;
    end
`ifdef WBACK_INSTRET_EN
    n_total++; if (instret_o !== exp_instret) $display("FAIL rnd_instret: got %0d want %0d", instret_o, exp_instret); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_load_write();
    test_x0();
    test_backpressure();
    test_csr();
    test_reset_mid();
`ifdef WBACK_INSTRET_EN
    test_instret();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
